// File: rtl/smc_pwm_engine_if.sv
// Register-file-to-PWM-engine link: period/duty writes in, coil drive pair and status out.
interface smc_pwm_engine_if #(
  parameter int CNT_W  = 11,
  parameter int N_COIL = 2
);
  localparam int SEL_W = (N_COIL > 1) ? $clog2(N_COIL) : 1;

  logic              en;
  logic              center;
  logic              per_wr;
  logic [CNT_W-1:0]  per_data;
  logic              dc_wr;
  logic [SEL_W-1:0]  dc_sel;
  logic [CNT_W:0]    dc_data;
  logic [N_COIL-1:0] MNP;
  logic [N_COIL-1:0] MNM;
  logic              period_end;
  logic              upd_pend;

  modport master (
    output en, center, per_wr, per_data, dc_wr, dc_sel, dc_data,
    input  MNP, MNM, period_end, upd_pend
  );

  modport slave (
    input  en, center, per_wr, per_data, dc_wr, dc_sel, dc_data,
    output MNP, MNM, period_end, upd_pend
  );
endinterface

// File: rtl/smc_pwm_engine.sv
// Per-motor PWM engine: left/center-aligned counter, double-buffered period and signed coil duties,
// active values reloaded only at the period boundary.
module smc_pwm_engine #(
  parameter int CNT_W  = 11,
  parameter int N_COIL = 2
) (
  input logic             QCLK,
  input logic             QRESET,
  smc_pwm_engine_if.slave bus
);
  localparam int SEL_W = (N_COIL > 1) ? $clog2(N_COIL) : 1;

  logic [CNT_W-1:0]  cnt;
  logic              dir_dn;
  logic [CNT_W-1:0]  buf_per, act_per, nxt_per;
  logic              act_center;
  logic [CNT_W:0]    buf_dc [N_COIL];
  logic [CNT_W:0]    act_dc [N_COIL];
  logic [CNT_W:0]    nxt_dc [N_COIL];
  logic [CNT_W-1:0]  mag    [N_COIL];
  logic [N_COIL-1:0] pwm, sgn;
  logic [N_COIL-1:0] mnp_q, mnm_q;
  logic              upd_q;
  logic              dc_hit, any_wr, running, last_cnt, top_cnt;

  always_comb begin
    dc_hit  = bus.dc_wr && (int'(bus.dc_sel) < N_COIL);
    any_wr  = bus.per_wr || dc_hit;
    nxt_per = bus.per_wr ? bus.per_data : buf_per;
    running = bus.en && (act_per != '0);
    top_cnt = (cnt == act_per - CNT_W'(1));
    last_cnt = act_center ? (dir_dn && (cnt == '0)) : top_cnt;
    pwm = '0;
    sgn = '0;
    for (int i = 0; i < N_COIL; i++) begin
      nxt_dc[i] = (dc_hit && (bus.dc_sel == SEL_W'(i))) ? bus.dc_data : buf_dc[i];
      mag[i]    = act_dc[i][CNT_W-1:0];
      sgn[i]    = act_dc[i][CNT_W];
      // center mode: saturate before the subtraction so |duty| >= PER cannot wrap
      if (act_center)
        pwm[i] = (mag[i] >= act_per) || (cnt >= act_per - mag[i]);
      else
        pwm[i] = (cnt < mag[i]);
    end
  end

  assign bus.period_end = running && last_cnt;
  assign bus.MNP        = mnp_q;
  assign bus.MNM        = mnm_q;
  assign bus.upd_pend   = upd_q;

  always_ff @(posedge QCLK) begin
    if (QRESET) begin
      cnt        <= '0;
      dir_dn     <= 1'b0;
      buf_per    <= '0;
      act_per    <= '0;
      act_center <= 1'b0;
      mnp_q      <= '0;
      mnm_q      <= '0;
      upd_q      <= 1'b0;
      for (int i = 0; i < N_COIL; i++) begin
        buf_dc[i] <= '0;
        act_dc[i] <= '0;
      end
    end else begin
      buf_per <= nxt_per;
      for (int i = 0; i < N_COIL; i++) buf_dc[i] <= nxt_dc[i];
      if (!running) begin
        // idle is transparent: writes land in the active set on the same edge
        cnt        <= '0;
        dir_dn     <= 1'b0;
        mnp_q      <= '0;
        mnm_q      <= '0;
        upd_q      <= 1'b0;
        act_per    <= nxt_per;
        act_center <= bus.center;
        for (int i = 0; i < N_COIL; i++) act_dc[i] <= nxt_dc[i];
      end else begin
        mnp_q <= pwm & ~sgn;
        mnm_q <= pwm & sgn;
        if (last_cnt) begin
          // boundary loads the pre-edge buffers; a coinciding write waits a period
          cnt        <= '0;
          dir_dn     <= 1'b0;
          act_per    <= buf_per;
          act_center <= bus.center;
          upd_q      <= any_wr;
          for (int i = 0; i < N_COIL; i++) act_dc[i] <= buf_dc[i];
        end else begin
          upd_q <= upd_q | any_wr;
          if (act_center && !dir_dn && top_cnt)
            dir_dn <= 1'b1;
          else if (dir_dn)
            cnt <= cnt - CNT_W'(1);
          else
            cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_smc_pwm_engine.sv
// Directed bench for smc_pwm_engine: per-cycle expectations queued as stimulus is driven.
module tb_smc_pwm_engine;
  logic QCLK;
  logic QRESET;
  int   total;
  int   fails;

  typedef struct {
    logic       pe;
    logic [1:0] mnp;
    logic [1:0] mnm;
    logic       pend;
  } sb_t;

  sb_t        sb[$];
  logic [1:0] prev_mnp;
  logic [1:0] prev_mnm;

  smc_pwm_engine_if #(.CNT_W(11), .N_COIL(2)) bus ();

  smc_pwm_engine #(.CNT_W(11), .N_COIL(2)) dut (
    .QCLK   (QCLK),
    .QRESET (QRESET),
    .bus    (bus)
  );

  initial QCLK = 1'b0;
  always #5 QCLK = ~QCLK;

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks the current cycle against the oldest queued entry, then advances one edge.
  // Drive outputs lag the entry that produced them by one cycle.
  task automatic cyc();
    sb_t e;
    #1;
    e = sb.pop_front();
    chk("period_end", {7'd0, bus.period_end}, {7'd0, e.pe});
    chk("upd_pend",   {7'd0, bus.upd_pend},   {7'd0, e.pend});
    chk("drive",      {2'd0, bus.MNP, 2'd0, bus.MNM}, {2'd0, prev_mnp, 2'd0, prev_mnm});
    prev_mnp = e.mnp;
    prev_mnm = e.mnm;
    @(posedge QCLK);
    #1;
  endtask

  task automatic idle_cyc();
    sb_t e;
    e.pe = 1'b0; e.mnp = 2'b00; e.mnm = 2'b00; e.pend = 1'b0;
    sb.push_back(e);
    cyc();
  endtask

  task automatic run_period(input int per, input bit ctr,
                            input int m0, input bit s0, input int m1, input bit s1,
                            input int wr_at, input bit wr_sel, input logic [11:0] wr_data,
                            input int rst_at, input bit pend_in, output bit pend_out);
    int len;
    bit pend;
    len  = ctr ? 2 * per : per;
    pend = pend_in;
    for (int k = 0; k < len; k++) begin
      int  c;
      bit  p0, p1;
      sb_t e;
      c  = (ctr && k >= per) ? (2 * per - 1 - k) : k;
      p0 = ctr ? ((m0 >= per) || (c >= per - m0)) : (c < m0);
      p1 = ctr ? ((m1 >= per) || (c >= per - m1)) : (c < m1);
      e.pe   = (k == len - 1);
      e.pend = pend;
      e.mnp  = {p1 & ~s1, p0 & ~s0};
      e.mnm  = {p1 & s1, p0 & s0};
      if (k == rst_at) begin
        e.mnp  = 2'b00;
        e.mnm  = 2'b00;
        QRESET = 1'b1;
      end
      if (k == wr_at) begin
        bus.dc_wr   = 1'b1;
        bus.dc_sel  = wr_sel;
        bus.dc_data = wr_data;
      end
      sb.push_back(e);
      cyc();
      bus.dc_wr = 1'b0;
      if (k == wr_at) pend = 1'b1;
      if (k == rst_at) break;
    end
    pend_out = (wr_at == len - 1);
  endtask

  initial begin
    bit pd;
    total    = 0;
    fails    = 0;
    prev_mnp = 2'b00;
    prev_mnm = 2'b00;
    QRESET       = 1'b1;
    bus.en       = 1'b0;
    bus.center   = 1'b0;
    bus.per_wr   = 1'b0;
    bus.per_data = '0;
    bus.dc_wr    = 1'b0;
    bus.dc_sel   = '0;
    bus.dc_data  = '0;
    repeat (2) @(posedge QCLK);
    #1;
    chk("rst_mnp",  {6'd0, bus.MNP}, 8'd0);
    chk("rst_mnm",  {6'd0, bus.MNM}, 8'd0);
    chk("rst_pe",   {7'd0, bus.period_end}, 8'd0);
    chk("rst_pend", {7'd0, bus.upd_pend}, 8'd0);
    QRESET = 1'b0;

    // program while idle: PER=10, coil0 +3, coil1 -4
    bus.per_wr = 1'b1; bus.per_data = 11'd10;
    bus.dc_wr = 1'b1; bus.dc_sel = 1'b0; bus.dc_data = 12'h003;
    idle_cyc();
    bus.per_wr = 1'b0;
    bus.dc_sel = 1'b1; bus.dc_data = 12'h804;
    idle_cyc();
    bus.dc_wr = 1'b0;
    bus.en = 1'b1;

    run_period(10, 0, 3, 0, 4, 1, -1, 1'b0, 12'h000, -1, 1'b0, pd);
    run_period(10, 0, 3, 0, 4, 1,  4, 1'b1, 12'h80C, -1, pd, pd);   // coil1 -> -12 mid-period
    run_period(10, 0, 3, 0, 12, 1, 9, 1'b0, 12'h007, -1, pd, pd);   // write coincident with boundary
    run_period(10, 0, 3, 0, 12, 1, -1, 1'b0, 12'h000, -1, pd, pd);
    run_period(10, 0, 7, 0, 12, 1, 3, 1'b0, 12'h002, -1, pd, pd);
    run_period(10, 0, 2, 0, 12, 1, -1, 1'b0, 12'h000, -1, pd, pd);

    // disable, reprogram center PER=8, coil0 +4, coil1 0
    bus.en = 1'b0;
    idle_cyc();
    bus.center = 1'b1;
    bus.per_wr = 1'b1; bus.per_data = 11'd8;
    bus.dc_wr = 1'b1; bus.dc_sel = 1'b0; bus.dc_data = 12'h004;
    idle_cyc();
    bus.per_wr = 1'b0;
    bus.dc_sel = 1'b1; bus.dc_data = 12'h000;
    idle_cyc();
    bus.dc_wr = 1'b0;
    bus.en = 1'b1;
    run_period(8, 1, 4, 0, 0, 0, -1, 1'b0, 12'h000, -1, 1'b0, pd);
    run_period(8, 1, 4, 0, 0, 0, -1, 1'b0, 12'h000, -1, pd, pd);

    // back to left PER=10, then reset at cnt=5 with a write pending
    bus.en = 1'b0;
    idle_cyc();
    bus.center = 1'b0;
    bus.per_wr = 1'b1; bus.per_data = 11'd10;
    idle_cyc();
    bus.per_wr = 1'b0;
    bus.en = 1'b1;
    run_period(10, 0, 4, 0, 0, 0, 2, 1'b0, 12'h009, 5, 1'b0, pd);
    QRESET = 1'b0;
    chk("post_rst_mnp",  {6'd0, bus.MNP}, 8'd0);
    chk("post_rst_mnm",  {6'd0, bus.MNM}, 8'd0);
    chk("post_rst_pend", {7'd0, bus.upd_pend}, 8'd0);
    prev_mnp = 2'b00;
    prev_mnm = 2'b00;
    repeat (5) idle_cyc();

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
